// File: rtl/if_fetch_stage_pkg.sv
// rtl/if_fetch_stage_pkg.sv - shared constants, FSM encoding and hold-buffer entry type for the IF stage
package if_fetch_stage_pkg;

    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;  // sll $0,$0,0
    localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_KILL  = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pcplus4;
    } hold_entry_t;

    function automatic logic [31:0] pc_incr(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_fetch_stage_hold_buf.sv
// rtl/if_fetch_stage_hold_buf.sv - 1-entry buffer for a fetched word that IF/ID cannot take yet
import if_fetch_stage_pkg::*;

module fetch_hold_buf (
    input  logic        clock,
    input  logic        reset,
    input  logic        load,
    input  logic        drain,
    input  logic        clear,
    input  hold_entry_t din,
    output hold_entry_t dout,
    output logic        full
);

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            full <= 1'b0;
            dout <= '0;
        end else if (load) begin
            full <= 1'b1;
            dout <= din;
        end else if (drain) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - IF stage: PC, imem request FSM, redirect mux, IF/ID register
// Optional FETCH_PERF_CNT_EN adds perf_fetch_cnt / perf_bubble_cnt outputs.
import if_fetch_stage_pkg::*;

module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        PC_write,
    input  logic        IFID_write,
    input  logic        PCSrc,
    input  logic        Jump,
    input  logic [31:0] branch_target,
    input  logic [31:0] jump_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PC,
    output logic [31:0] IFID_instr,
    output logic [31:0] IFID_PCplus4,
    output logic        IFID_valid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_bubble_cnt
`endif
);

    fetch_state_t state, state_next;
    logic [31:0]  pc_next;
    logic [31:0]  kill_addr;
    logic         kill_load;
    logic         redirect;
    logic [31:0]  target;
    logic         word_avail;
    hold_entry_t  word;
    hold_entry_t  buf_dout;
    logic         buf_load, buf_drain, buf_clear, buf_full;

    assign redirect = Jump | PCSrc;
    assign target   = Jump ? jump_target : branch_target;

    fetch_hold_buf u_hold_buf (
        .clock (clock),
        .reset (reset),
        .load  (buf_load),
        .drain (buf_drain),
        .clear (buf_clear),
        .din   ('{instr: imem_rdata, pcplus4: pc_incr(PC)}),
        .dout  (buf_dout),
        .full  (buf_full)
    );

    always_comb begin
        state_next = state;
        pc_next    = PC;
        imem_req   = 1'b0;
        imem_addr  = PC;
        kill_load  = 1'b0;
        buf_load   = 1'b0;
        buf_drain  = 1'b0;
        buf_clear  = 1'b0;
        word_avail = 1'b0;
        word       = '{instr: imem_rdata, pcplus4: pc_incr(PC)};
        case (state)
            ST_FETCH: begin
                imem_req = 1'b1;
                if (redirect) begin
                    pc_next = target;
                    if (!imem_ready) begin
                        kill_load  = 1'b1;
                        state_next = ST_KILL;
                    end
                end else if (imem_ready) begin
                    if (PC_write) pc_next = pc_incr(PC);
                    if (PC_write && IFID_write) begin
                        word_avail = 1'b1;
                    end else begin
                        buf_load   = 1'b1;
                        state_next = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (redirect) begin
                    buf_clear  = 1'b1;
                    pc_next    = target;
                    state_next = ST_FETCH;
                end else if (PC_write && IFID_write && buf_full) begin
                    // PC may already have advanced at capture; the entry's PC+4 is correct either way
                    buf_drain  = 1'b1;
                    word_avail = 1'b1;
                    word       = buf_dout;
                    pc_next    = buf_dout.pcplus4;
                    state_next = ST_FETCH;
                end
            end
            ST_KILL: begin
                imem_req  = 1'b1;
                imem_addr = kill_addr;
                if (redirect) pc_next = target;
                if (imem_ready) state_next = ST_FETCH;
            end
            default: state_next = ST_FETCH;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_FETCH;
            PC        <= RESET_PC;
            kill_addr <= RESET_PC;
        end else begin
            state <= state_next;
            PC    <= pc_next;
            if (kill_load) kill_addr <= PC;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            IFID_instr   <= NOP_INSTR;
            IFID_PCplus4 <= 32'h0;
            IFID_valid   <= 1'b0;
        end else if (redirect) begin
            IFID_instr <= NOP_INSTR;
            IFID_valid <= 1'b0;
        end else if (IFID_write) begin
            if (word_avail) begin
                IFID_instr   <= word.instr;
                IFID_PCplus4 <= word.pcplus4;
                IFID_valid   <= 1'b1;
            end else begin
                IFID_instr <= NOP_INSTR;
                IFID_valid <= 1'b0;
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_fetch_cnt  <= 32'h0;
            perf_bubble_cnt <= 32'h0;
        end else if (redirect || IFID_write) begin
            if (!redirect && word_avail) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            else                         perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
        end
    end
`endif

endmodule
